cr_clic_arb_seq: RTL
====================

CR_CLIC_ARB_SEQ -- requirements
Module: cr_clic_arb_seq

Interface
REQ-001 SHALL have parameter INT_NUM, default 16, number of interrupt kids (multiple of GRP_NUM).
REQ-002 SHALL have parameter GRP_NUM, default 4, kids examined per scan cycle.
REQ-003 SHALL have parameter CLICINTCTLBITS, default 3; per-kid priority key width KW = CLICINTCTLBITS+1.
REQ-004 SHALL use one clock and a synchronous, active-low reset, as the ports below define.
REQ-005 clic_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 cpurst_b  input  1  synchronous active-low reset.
REQ-007 ctrl_arb_en  input  1  arbiter enable (CLIC global enable).
REQ-008 kid_arb_int_req  input  INT_NUM  per-kid pending-and-enabled request.
REQ-009 kid_arb_int_all  input  INT_NUM*KW  per-kid priority key; kid i is bits [i*KW +: KW].
REQ-010 kid_arb_int_hv  input  INT_NUM  per-kid hardware-vectored flag.
REQ-011 ctrl_arb_int_ack  input  1  single-cycle pulse: core has taken the presented interrupt.
REQ-012 ctrl_arb_rescan  input  1  single-cycle pulse: kid configuration changed, rearbitrate.
REQ-013 arb_ctrl_int_vld  output  1  winner valid.
REQ-014 arb_ctrl_int_id  output  log2(INT_NUM)  winner kid index.
REQ-015 arb_ctrl_int_key  output  KW  winner priority key.
REQ-016 arb_ctrl_int_hv  output  1  winner hv flag.
REQ-017 arb_ctrl_busy  output  1  high while state is SCAN.

Function
REQ-018 FSM SHALL have the states IDLE, SCAN and HOLD; group counter grp_cnt runs 0..INT_NUM/GRP_NUM-1.
REQ-019 IDLE: if ctrl_arb_en and |kid_arb_int_req, go to SCAN next cycle with grp_cnt=0 and the best-so-far register cleared (found=0).
REQ-020 SCAN: each cycle SHALL examine kids grp_cnt*GRP_NUM..+GRP_NUM-1 as sampled that cycle and update best-so-far, then increment grp_cnt.
REQ-021 A candidate SHALL replace best-so-far only if its req=1 and (found=0 or its key > best key); on an equal key the lower id wins (strict >, ascending scan order).
REQ-022 On the last group, the final best SHALL be committed to the outputs at that edge: vld=found, id/key/hv=best; next state is HOLD if found, else IDLE.
REQ-023 Latency: with req sampled in IDLE at cycle 0, SCAN runs cycles 1..INT_NUM/GRP_NUM, and vld is high in cycle INT_NUM/GRP_NUM+1 (cycle 5 with defaults).
REQ-024 HOLD: outputs SHALL stay stable; on ack, vld clears next cycle and the state goes to IDLE; on rescan without ack, go to SCAN with vld and the old winner still presented until the new commit.
REQ-025 ack and rescan in the same cycle: ack SHALL take priority.
REQ-026 ack outside HOLD SHALL be ignored; rescan in IDLE SHALL act as an IDLE entry check; rescan in SCAN SHALL restart at grp_cnt=0.
REQ-027 ctrl_arb_en low in any state SHALL force IDLE next cycle, clear vld, and abort the scan.
REQ-028 A req that drops after its group was examined SHALL NOT affect the committed result; the core resolves stale winners via rescan.

Reset
REQ-029 Reset SHALL set: state=IDLE, grp_cnt=0, found=0, arb_ctrl_int_vld=0, arb_ctrl_int_id=0, arb_ctrl_int_key=0, arb_ctrl_int_hv=0, arb_ctrl_busy=0.
REQ-030 Reset asserted mid-SCAN or in HOLD SHALL discard the partial result; no output is valid on the cycle after reset.

Structure
REQ-031 The FSM state encoding (IDLE=2'b00, SCAN=2'b01, HOLD=2'b10) and the default widths SHALL live in the shared CLIC constants include.
REQ-032 The GRP_NUM-input max-key/lowest-id comparator SHALL be the sub-module cr_clic_arb_cmp (combinational), instantiated once.

Verification
REQ-033 Reset held 3 cycles, then release with no req -> state IDLE; vld=0 and busy=0 indefinitely.
REQ-034 Only kid 9 req with key 4'h5 at cycle 0 -> vld=1, id=9, key=5 in cycle 5; busy high in cycles 1-4.
REQ-035 Kids 2 and 13 both with key 4'h7, kid 6 with key 4'h3 -> id=2; then ack -> vld=0 next cycle, rescan finds id=13 once kid 2's req drops.
REQ-036 In HOLD with id=9, raise kid 1 to key 4'hF and pulse rescan -> vld stays 1 with id=9 through the scan, then id=1, key=F.
REQ-037 Same-cycle ack+rescan in HOLD -> vld=0 next cycle, IDLE; en low during SCAN cycle 2 -> IDLE, vld=0; reset in SCAN -> all outputs 0.

Source files
------------

// File: rtl/cr_clic_arb_seq_pkg.sv
// Shared CLIC arbiter constants: default widths, FSM state encoding, width helper.
package cr_clic_arb_seq_pkg;

  localparam int unsigned CLIC_INT_NUM    = 16;
  localparam int unsigned CLIC_GRP_NUM    = 4;
  localparam int unsigned CLIC_INTCTLBITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_HOLD = 2'b10
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cr_clic_arb_seq_if.sv
// Kid/controller side of the CLIC arbiter; slave = arbiter, master = its environment.
interface cr_clic_arb_seq_if
  import cr_clic_arb_seq_pkg::*;
#(
  parameter int unsigned INT_NUM        = CLIC_INT_NUM,
  parameter int unsigned CLICINTCTLBITS = CLIC_INTCTLBITS
);

  localparam int unsigned KW  = CLICINTCTLBITS + 1;
  localparam int unsigned IDW = clog2_min1(INT_NUM);

  logic                  ctrl_arb_en;
  logic [INT_NUM-1:0]    kid_arb_int_req;
  logic [INT_NUM*KW-1:0] kid_arb_int_all;
  logic [INT_NUM-1:0]    kid_arb_int_hv;
  logic                  ctrl_arb_int_ack;
  logic                  ctrl_arb_rescan;
  logic                  arb_ctrl_int_vld;
  logic [IDW-1:0]        arb_ctrl_int_id;
  logic [KW-1:0]         arb_ctrl_int_key;
  logic                  arb_ctrl_int_hv;
  logic                  arb_ctrl_busy;

  modport slave (
    input  ctrl_arb_en, kid_arb_int_req, kid_arb_int_all, kid_arb_int_hv,
    input  ctrl_arb_int_ack, ctrl_arb_rescan,
    output arb_ctrl_int_vld, arb_ctrl_int_id, arb_ctrl_int_key, arb_ctrl_int_hv,
    output arb_ctrl_busy
  );

  modport master (
    output ctrl_arb_en, kid_arb_int_req, kid_arb_int_all, kid_arb_int_hv,
    output ctrl_arb_int_ack, ctrl_arb_rescan,
    input  arb_ctrl_int_vld, arb_ctrl_int_id, arb_ctrl_int_key, arb_ctrl_int_hv,
    input  arb_ctrl_busy
  );

endinterface

// File: rtl/cr_clic_arb_cmp.sv
// Combinational GRP_NUM-way comparator: highest key among requesters, lowest index on ties.
module cr_clic_arb_cmp
  import cr_clic_arb_seq_pkg::*;
#(
  parameter int unsigned GRP_NUM = CLIC_GRP_NUM,
  parameter int unsigned KW      = CLIC_INTCTLBITS + 1
) (
  input  logic [GRP_NUM-1:0]         i_req,
  input  logic [GRP_NUM*KW-1:0]      i_key,
  output logic                       o_found,
  output logic [clog2_min1(GRP_NUM)-1:0] o_idx,
  output logic [KW-1:0]              o_key
);

  localparam int unsigned GIW = clog2_min1(GRP_NUM);

  logic [KW-1:0] w_k;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    o_key   = '0;
    w_k     = '0;
    for (int unsigned i = 0; i < GRP_NUM; i++) begin
      w_k = KW'(i_key >> (i * KW));
      // strict > in ascending order keeps the lowest index on equal keys
      if (1'(i_req >> i) && (!o_found || (w_k > o_key))) begin
        o_found = 1'b1;
        o_idx   = GIW'(i);
        o_key   = w_k;
      end
    end
  end

endmodule

// File: rtl/cr_clic_arb_seq.sv
// Sequential CLIC arbiter: scans GRP_NUM kids per cycle, presents the winner until ack.
module cr_clic_arb_seq
  import cr_clic_arb_seq_pkg::*;
#(
  parameter int unsigned INT_NUM        = CLIC_INT_NUM,
  parameter int unsigned GRP_NUM        = CLIC_GRP_NUM,
  parameter int unsigned CLICINTCTLBITS = CLIC_INTCTLBITS
) (
  input  logic               clic_clk,
  input  logic               cpurst_b,
  cr_clic_arb_seq_if.slave   bus
);

  localparam int unsigned KW   = CLICINTCTLBITS + 1;
  localparam int unsigned NGRP = INT_NUM / GRP_NUM;
  localparam int unsigned IDW  = clog2_min1(INT_NUM);
  localparam int unsigned CW   = clog2_min1(NGRP);
  localparam int unsigned GIW  = clog2_min1(GRP_NUM);
  localparam int unsigned GKW  = GRP_NUM * KW;
  localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

  arb_state_e     r_state;
  logic [CW-1:0]  r_grp_cnt;
  logic           r_found;
  logic [IDW-1:0] r_best_id;
  logic [KW-1:0]  r_best_key;
  logic           r_best_hv;
  logic           r_vld;
  logic [IDW-1:0] r_id;
  logic [KW-1:0]  r_key;
  logic           r_hv;
  logic           r_busy;

  logic [IDW-1:0]     w_base;
  logic [GRP_NUM-1:0] w_grp_req;
  logic [GRP_NUM-1:0] w_grp_hv;
  logic [GKW-1:0]     w_grp_key;
  logic               w_g_found;
  logic [GIW-1:0]     w_g_idx;
  logic [KW-1:0]      w_g_key;
  logic [IDW-1:0]     w_cand_id;
  logic               w_cand_hv;
  logic               w_take;
  logic               w_nxt_found;
  logic [IDW-1:0]     w_nxt_id;
  logic [KW-1:0]      w_nxt_key;
  logic               w_nxt_hv;

  assign w_base    = IDW'(r_grp_cnt * GRP_NUM);
  assign w_grp_req = GRP_NUM'(bus.kid_arb_int_req >> w_base);
  assign w_grp_hv  = GRP_NUM'(bus.kid_arb_int_hv >> w_base);
  assign w_grp_key = GKW'(bus.kid_arb_int_all >> (w_base * KW));

  cr_clic_arb_cmp #(
    .GRP_NUM (GRP_NUM),
    .KW      (KW)
  ) u_cmp (
    .i_req   (w_grp_req),
    .i_key   (w_grp_key),
    .o_found (w_g_found),
    .o_idx   (w_g_idx),
    .o_key   (w_g_key)
  );

  // later groups only win on a strictly greater key, so equal keys keep the lower id
  assign w_cand_id   = w_base + IDW'(w_g_idx);
  assign w_cand_hv   = 1'(w_grp_hv >> w_g_idx);
  assign w_take      = w_g_found && (!r_found || (w_g_key > r_best_key));
  assign w_nxt_found = r_found | w_g_found;
  assign w_nxt_id    = w_take ? w_cand_id : r_best_id;
  assign w_nxt_key   = w_take ? w_g_key   : r_best_key;
  assign w_nxt_hv    = w_take ? w_cand_hv : r_best_hv;

  always_ff @(posedge clic_clk) begin
    if (!cpurst_b) begin
      r_state    <= ST_IDLE;
      r_grp_cnt  <= '0;
      r_found    <= 1'b0;
      r_best_id  <= '0;
      r_best_key <= '0;
      r_best_hv  <= 1'b0;
      r_vld      <= 1'b0;
      r_id       <= '0;
      r_key      <= '0;
      r_hv       <= 1'b0;
      r_busy     <= 1'b0;
    end else if (!bus.ctrl_arb_en) begin
      r_state   <= ST_IDLE;
      r_grp_cnt <= '0;
      r_found   <= 1'b0;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.kid_arb_int_req) begin
            r_state    <= ST_SCAN;
            r_grp_cnt  <= '0;
            r_found    <= 1'b0;
            r_best_id  <= '0;
            r_best_key <= '0;
            r_best_hv  <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (bus.ctrl_arb_rescan) begin
            r_grp_cnt  <= '0;
            r_found    <= 1'b0;
            r_best_id  <= '0;
            r_best_key <= '0;
            r_best_hv  <= 1'b0;
          end else begin
            r_found    <= w_nxt_found;
            r_best_id  <= w_nxt_id;
            r_best_key <= w_nxt_key;
            r_best_hv  <= w_nxt_hv;
            if (r_grp_cnt == LAST_GRP) begin
              r_grp_cnt <= '0;
              r_vld     <= w_nxt_found;
              r_id      <= w_nxt_id;
              r_key     <= w_nxt_key;
              r_hv      <= w_nxt_hv;
              r_state   <= w_nxt_found ? ST_HOLD : ST_IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_grp_cnt <= r_grp_cnt + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.ctrl_arb_int_ack) begin
            r_vld   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (bus.ctrl_arb_rescan) begin
            r_state    <= ST_SCAN;
            r_grp_cnt  <= '0;
            r_found    <= 1'b0;
            r_best_id  <= '0;
            r_best_key <= '0;
            r_best_hv  <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.arb_ctrl_int_vld = r_vld;
  assign bus.arb_ctrl_int_id  = r_id;
  assign bus.arb_ctrl_int_key = r_key;
  assign bus.arb_ctrl_int_hv  = r_hv;
  assign bus.arb_ctrl_busy    = r_busy;

endmodule
